// File: rtl/product_writeback_if.sv
// Handshake bundle between the multiplier stage, the product writeback block
// and the data memory write port.
interface product_writeback_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_product;
  logic [ADDR_W-1:0] in_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;

  // Environment side: offers products and answers memory writes.
  modport master (
    output in_valid, in_product, in_addr, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Writeback block side.
  modport slave (
    input  in_valid, in_product, in_addr, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/product_writeback.sv
// Product writeback: buffers sign-magnitude products, converts them to two's
// complement, and writes each as two bytes (high at base, low at base+1).
module product_writeback #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                clock,
  input  logic                reset,
  product_writeback_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic [7:0]          count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_HI = 2'd1,
    WR_LO = 2'd2
  } state_t;

  // Negative zero collapses to zero; other negatives are negated.
  function automatic logic [15:0] to_twos(input logic [15:0] p);
    logic [15:0] mag;
    mag = {1'b0, p[14:0]};
    if (p[15] && (p[14:0] != 15'd0)) begin
      to_twos = 16'd0 - mag;
    end else begin
      to_twos = mag;
    end
  endfunction

  logic [15:0]       val_mem_q  [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        lo_byte_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              done_q;
  logic [7:0]        count_q;

  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic [15:0]       head_val_s;
  logic [ADDR_W-1:0] head_addr_s;

  assign full_s      = (occ_q == OCC_W'(DEPTH));
  assign empty_s     = (occ_q == {OCC_W{1'b0}});
  assign push_s      = bus.in_valid & ~full_s;
  assign head_val_s  = val_mem_q[rd_ptr_q];
  assign head_addr_s = addr_mem_q[rd_ptr_q];

  assign bus.in_ready  = ~full_s;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state_q != IDLE) | ~empty_s;
  assign done          = done_q;
  assign count         = count_q;

  // Pop whenever the FSM is ready to start a new product and one is waiting.
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      IDLE:    pop_s = ~empty_s;
      WR_LO:   pop_s = ~empty_s & bus.mem_ack;
      default: pop_s = 1'b0;
    endcase
  end

  // Next pointer and occupancy values for the wrap-around FIFO.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // FIFO pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // FIFO storage; the product is converted on the way in.
  always_ff @(posedge clock) begin
    if (!reset && push_s) begin
      val_mem_q[wr_ptr_q]  <= to_twos(bus.in_product);
      addr_mem_q[wr_ptr_q] <= bus.in_addr;
    end
  end

  // Write FSM with registered memory-port outputs, done pulse and counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= {ADDR_W{1'b0}};
      lo_byte_q   <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 8'd0;
      done_q      <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!empty_s) begin
            state_q     <= WR_HI;
            base_q      <= head_addr_s;
            lo_byte_q   <= head_val_s[7:0];
            mem_we_q    <= 1'b1;
            mem_addr_q  <= head_addr_s;
            mem_wdata_q <= head_val_s[15:8];
          end
        end
        WR_HI: begin
          if (bus.mem_ack) begin
            state_q     <= WR_LO;
            mem_addr_q  <= base_q + ADDR_W'(1);
            mem_wdata_q <= lo_byte_q;
          end
        end
        WR_LO: begin
          if (bus.mem_ack) begin
            done_q  <= 1'b1;
            count_q <= count_q + 8'd1;
            if (!empty_s) begin
              state_q     <= WR_HI;
              base_q      <= head_addr_s;
              lo_byte_q   <= head_val_s[7:0];
              mem_we_q    <= 1'b1;
              mem_addr_q  <= head_addr_s;
              mem_wdata_q <= head_val_s[15:8];
            end else begin
              state_q  <= IDLE;
              mem_we_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_writeback.sv
// Bench for product_writeback: directed stimulus, a queue-based model of the
// expected byte writes, and literal checks of the documented examples.
module tb_product_writeback;

  logic       clock;
  logic       reset;
  logic       busy;
  logic       done;
  logic [7:0] count;

  product_writeback_if #(.ADDR_W(8)) bus ();

  product_writeback #(.ADDR_W(8), .DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    bit         lo;
  } wr_t;

  wr_t        q[$];
  int         checks;
  int         errors;
  bit         armed;
  bit         done_exp;
  logic [7:0] cnt_m;
  bit         pend;
  logic [7:0] p_addr;
  logic [7:0] p_data;
  bit         last_acc;
  int         done_pulses;
  logic [7:0] log_a [1024];
  logic [7:0] log_d [1024];
  int         log_n;
  logic       s_we, s_done, s_busy, s_ready;
  logic [7:0] s_addr, s_data, s_count;

  // Value stored in memory: signed integer of the sign-magnitude product.
  function automatic logic [15:0] expect_val(input logic [15:0] p);
    int m;
    int v;
    m = int'(p[14:0]);
    v = p[15] ? -m : m;
    return v[15:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of the DUT against the model, at the falling edge.
  task automatic monitor();
    wr_t         e;
    logic [15:0] v;
    last_acc = 1'b0;
    s_we = bus.mem_we; s_addr = bus.mem_addr; s_data = bus.mem_wdata;
    s_done = done; s_busy = busy; s_count = count; s_ready = bus.in_ready;
    if (reset) begin
      q.delete();
      cnt_m    = 8'd0;
      done_exp = 1'b0;
      pend     = 1'b0;
      armed    = 1'b1;
      return;
    end
    if (!armed) return;
    chk("done", {31'd0, done}, {31'd0, done_exp});
    chk("count", {24'd0, count}, {24'd0, cnt_m});
    if (pend) begin
      chk("hold_we", {31'd0, bus.mem_we}, 32'd1);
      chk("hold_addr", {24'd0, bus.mem_addr}, {24'd0, p_addr});
      chk("hold_data", {24'd0, bus.mem_wdata}, {24'd0, p_data});
    end
    if (done) done_pulses++;
    done_exp = 1'b0;
    if (bus.mem_we && bus.mem_ack) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got addr %0h data %0h want none", bus.mem_addr, bus.mem_wdata);
      end else begin
        e = q.pop_front();
        chk("wr_addr", {24'd0, bus.mem_addr}, {24'd0, e.a});
        chk("wr_data", {24'd0, bus.mem_wdata}, {24'd0, e.d});
        if (e.lo) begin
          done_exp = 1'b1;
          cnt_m    = cnt_m + 8'd1;
        end
      end
      if (log_n < 1024) begin
        log_a[log_n] = bus.mem_addr;
        log_d[log_n] = bus.mem_wdata;
      end
      log_n++;
    end
    pend   = bus.mem_we && !bus.mem_ack;
    p_addr = bus.mem_addr;
    p_data = bus.mem_wdata;
    if (bus.in_valid && bus.in_ready) begin
      last_acc = 1'b1;
      v = expect_val(bus.in_product);
      q.push_back('{a: bus.in_addr, d: v[15:8], lo: 1'b0});
      q.push_back('{a: bus.in_addr + 8'd1, d: v[7:0], lo: 1'b1});
    end
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("rst_we", {31'd0, s_we}, 32'd0);
    chk("rst_done", {31'd0, s_done}, 32'd0);
    chk("rst_busy", {31'd0, s_busy}, 32'd0);
    chk("rst_count", {24'd0, s_count}, 32'd0);
    chk("rst_ready", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic send(input logic [15:0] p, input logic [7:0] a);
    bit got;
    got = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    bus.in_addr    = a;
    for (int i = 0; i < 200; i++) begin
      step();
      if (last_acc) begin
        got = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got no accept want accept of %0h", p);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!s_busy && !s_we) begin
        idle = 1'b1;
        break;
      end
    end
    step();
    step();
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy want idle");
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [7:0] a, input logic [7:0] d);
    chk({nm, "_addr"}, {24'd0, log_a[idx]}, {24'd0, a});
    chk({nm, "_data"}, {24'd0, log_d[idx]}, {24'd0, d});
  endtask

  initial begin
    int lb;
    int dp;
    checks = 0; errors = 0; armed = 1'b0; done_exp = 1'b0; cnt_m = 8'd0;
    pend = 1'b0; done_pulses = 0; log_n = 0; last_acc = 1'b0;
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_product = 16'h1234;
    bus.in_addr = 8'h00;
    bus.mem_ack = 1'b1;
    step();
    bus.in_valid = 1'b0;
    do_reset();

    // Latency and positive product.
    lb = log_n; dp = done_pulses;
    bus.in_valid = 1'b1; bus.in_product = 16'h0123; bus.in_addr = 8'h10;
    step();
    chk("lat_accept", {31'd0, last_acc}, 32'd1);
    bus.in_valid = 1'b0;
    step();
    chk("lat_n1_we", {31'd0, s_we}, 32'd0);
    step();
    chk("lat_n2_we", {31'd0, s_we}, 32'd1);
    chk("lat_n2_addr", {24'd0, s_addr}, 32'h10);
    chk("lat_n2_data", {24'd0, s_data}, 32'h01);
    step();
    chk("lat_n3_addr", {24'd0, s_addr}, 32'h11);
    chk("lat_n3_data", {24'd0, s_data}, 32'h23);
    step();
    chk("lat_n4_done", {31'd0, s_done}, 32'd1);
    chk("lat_n4_we", {31'd0, s_we}, 32'd0);
    step();
    chk("lat_n5_done", {31'd0, s_done}, 32'd0);
    chk("pos_count", {24'd0, s_count}, 32'd1);
    chk("pos_pulses", done_pulses - dp, 32'd1);
    chk_log("pos_w0", lb, 8'h10, 8'h01);
    chk_log("pos_w1", lb + 1, 8'h11, 8'h23);

    // Negative products, negative zero and address wrap.
    lb = log_n;
    send(16'h8005, 8'h20);
    send(16'hFFFF, 8'h30);
    send(16'h8000, 8'h50);
    send(16'h7FFF, 8'hFF);
    wait_idle();
    chk_log("neg5_hi", lb, 8'h20, 8'hFF);
    chk_log("neg5_lo", lb + 1, 8'h21, 8'hFB);
    chk_log("negmax_hi", lb + 2, 8'h30, 8'h80);
    chk_log("negmax_lo", lb + 3, 8'h31, 8'h01);
    chk_log("negzero_hi", lb + 4, 8'h50, 8'h00);
    chk_log("negzero_lo", lb + 5, 8'h51, 8'h00);
    chk_log("wrap_hi", lb + 6, 8'hFF, 8'h7F);
    chk_log("wrap_lo", lb + 7, 8'h00, 8'hFF);
    chk("neg_count", {24'd0, s_count}, 32'd5);

    // Backpressure with memory stalled.
    do_reset();
    lb = log_n;
    bus.mem_ack = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_product = 16'h0102; bus.in_addr = 8'h60; step();
    chk("bp_A_acc", {31'd0, last_acc}, 32'd1);
    bus.in_product = 16'h0304; bus.in_addr = 8'h62; step();
    chk("bp_B_acc", {31'd0, last_acc}, 32'd1);
    bus.in_product = 16'h8001; bus.in_addr = 8'h64; step();
    chk("bp_C_acc", {31'd0, last_acc}, 32'd1);
    bus.in_product = 16'h0000; bus.in_addr = 8'h66;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_D_blocked", {31'd0, s_ready}, 32'd0);
      chk("bp_A_addr", {24'd0, s_addr}, 32'h60);
      chk("bp_A_data", {24'd0, s_data}, 32'h01);
    end
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_acc) break;
    end
    chk("bp_D_acc", {31'd0, last_acc}, 32'd1);
    bus.in_valid = 1'b0;
    wait_idle();
    chk_log("bp_0", lb, 8'h60, 8'h01);
    chk_log("bp_1", lb + 1, 8'h61, 8'h02);
    chk_log("bp_2", lb + 2, 8'h62, 8'h03);
    chk_log("bp_3", lb + 3, 8'h63, 8'h04);
    chk_log("bp_4", lb + 4, 8'h64, 8'hFF);
    chk_log("bp_5", lb + 5, 8'h65, 8'hFF);
    chk_log("bp_6", lb + 6, 8'h66, 8'h00);
    chk_log("bp_7", lb + 7, 8'h67, 8'h00);
    chk("bp_count", {24'd0, s_count}, 32'd4);

    // Count wrap: 252 more products bring the counter from 4 back to 0.
    for (int i = 0; i < 252; i++) begin
      send(16'(i * 131), 8'(i));
    end
    wait_idle();
    chk("wrap_count", {24'd0, s_count}, 32'd0);

    // Reset while in WR_LO with one product buffered.
    bus.mem_ack = 1'b0;
    send(16'h0A0B, 8'h40);
    step();
    step();
    send(16'h0C0D, 8'h44);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    step();
    chk("mid_lo_addr", {24'd0, s_addr}, 32'h41);
    chk("mid_lo_we", {31'd0, s_we}, 32'd1);
    dp = done_pulses;
    lb = log_n;
    do_reset();
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abandon_we", {31'd0, s_we}, 32'd0);
    end
    chk("abandon_pulses", done_pulses - dp, 32'd0);
    chk("abandon_writes", log_n - lb, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
